serial_add_sequencer: RTL and testbench
=======================================

Name: serial_add_sequencer

Overview:
Bit-serial controller that time-shares one external single-bit full-adder cell (tt_um_full_adder datapath) to add or subtract two WIDTH-bit operands, LSB first, one bit per enabled clock. It sits between the tile's I/O decode logic and the full-adder cell. It latches operands on a start pulse, drives the adder's a/b/cin each cycle, and collects sum bits and the carry. It reports completion with a one-cycle done pulse and holds the result.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..16.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  tile enable; low freezes all state
start  in  1  request; sampled only in IDLE with ena=1
sub  in  1  0=add, 1=subtract (A - B); latched on start
op_a  in  WIDTH  operand A; latched on start
op_b  in  WIDTH  operand B; latched on start
cin  in  1  carry-in for add; ignored when sub=1
fa_a  out  1  to full adder: current A bit
fa_b  out  1  to full adder: current B bit (inverted when subtracting)
fa_cin  out  1  to full adder: running carry
fa_sum  in  1  from full adder: sum bit
fa_cout  in  1  from full adder: carry out
busy  out  1  high in RUN
done  out  1  one-cycle pulse when result is valid
sum  out  WIDTH  result; held until next accepted start
cout  out  1  final carry; for sub, 1 = no borrow

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sum=0, cout=0, fa_a/fa_b/fa_cin=0, bit counter=0, carry register=0.
- States: IDLE, RUN, DONE.
- IDLE, ena=1, start=1 (edge 0):
  - latch a_sh=op_a, b_sh=sub ? ~op_b : op_b
  - carry=sub ? 1 : cin; cnt=0; go to RUN.
  - sum/cout are not cleared until the first bit shifts in.
- RUN: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry, all registered-state-driven with no combinational path from ports.
  - On each enabled edge: result shift register shifts right with fa_sum in at MSB; carry<=fa_cout; a_sh/b_sh shift right; cnt++.
  - When cnt reaches WIDTH-1 on that edge: cout<=fa_cout, go to DONE.
  - Exactly WIDTH RUN cycles.
- DONE: done=1 for exactly one enabled cycle; busy=0; sum/cout valid; next edge returns to IDLE.
  - Latency: start at edge 0 gives done high in the cycle after edge WIDTH, so a WIDTH=8 add has done visible after edge 8 and before edge 9.
- Outside RUN: fa_a=fa_b=fa_cin=0.
- start in RUN or DONE is ignored; no queueing.
- start held high continuously produces a new operation on each return to IDLE, giving a back-to-back throughput of one per WIDTH+2 cycles.
- ena=0: every register holds, including state, counter and done. A done pulse stretches until ena returns; the pulse still lasts one enabled cycle.
- Reset mid-RUN: operation aborted; all outputs return to reset values; no done.
- Arithmetic is modulo 2^WIDTH. For sub, cout=1 when A>=B unsigned.
- The counter is $clog2(WIDTH) bits wide. Wrap-around is impossible because the exit is at WIDTH-1.

Decomposition:
- Package serial_add_pkg: state enum (IDLE, RUN, DONE), WIDTH_DEFAULT=8, counter-width function.
- One sub-module, serial_shift_reg: parameterised WIDTH, right-shift with load, enable, serial in/out. Instantiated three times (A, B, result).
- The full-adder cell stays external and is connected through the fa_* ports.

Test Plan:
- Add: op_a=8'h3C, op_b=8'h5A, cin=0 -> done after 8 RUN cycles, sum=8'h96, cout=0; busy high exactly 8 cycles.
- Add with carry out: op_a=8'hFF, op_b=8'h01, cin=0 -> sum=8'h00, cout=1. Repeat with cin=1 and op_b=8'h00 -> sum=8'h00, cout=1.
- Subtract: sub=1, op_a=8'h10, op_b=8'h01 -> sum=8'h0F, cout=1. Then op_a=8'h01, op_b=8'h02 -> sum=8'hFF, cout=0.
- Start during RUN with different operands: the first result is unaffected and only one done pulse occurs; the second operation starts only after IDLE is re-entered.
- ena low for 3 cycles mid-RUN: total latency grows by 3; result is still correct; fa_* hold stable while stalled.
- rst_n low at RUN cycle 4: busy, done, sum and cout go to 0 immediately (async); after release, a new add of 8'h01+8'h01 returns sum=8'h02.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add/subtract sequencer.
package serial_add_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Request/result bus between the tile I/O decode logic and the sequencer.
interface serial_add_sequencer_if #(
    parameter int unsigned WIDTH = serial_add_pkg::WIDTH_DEFAULT
) ();

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, sub, op_a, op_b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, sub, op_a, op_b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_add_sequencer_shift_reg.sv
// Right-shift register with parallel load and enable; exposes the low OUT_WIDTH bits,
// so OUT_WIDTH=1 gives a plain serial output.
module serial_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned OUT_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    input  logic                 ser_in,
    output logic [OUT_WIDTH-1:0] q
);

    logic [WIDTH-1:0] data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (en) begin
            if (load) begin
                data <= load_val;
            end else begin
                data <= {ser_in, data[WIDTH-1:1]};
            end
        end
    end

    assign q = data[OUT_WIDTH-1:0];

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract controller time-sharing an external one-bit full-adder cell,
// LSB first, one bit per enabled clock.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    serial_add_sequencer_if.slave  bus,
    output logic                   fa_a,
    output logic                   fa_b,
    output logic                   fa_cin,
    input  logic                   fa_sum,
    input  logic                   fa_cout
);

    localparam int unsigned    CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             carry, carry_next;
    logic             cout_q, cout_next;
    logic             load, shift;
    logic             a_lsb, b_lsb;
    logic [WIDTH-1:0] b_init;
    logic [WIDTH-1:0] res;

    // Subtraction is A + ~B + 1: invert B at load, force the initial carry.
    assign b_init = bus.sub ? ~bus.op_b : bus.op_b;

    serial_shift_reg #(.WIDTH(WIDTH), .OUT_WIDTH(1)) u_a_sh (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (load | shift),
        .load     (load),
        .load_val (bus.op_a),
        .ser_in   (1'b0),
        .q        (a_lsb)
    );

    serial_shift_reg #(.WIDTH(WIDTH), .OUT_WIDTH(1)) u_b_sh (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (load | shift),
        .load     (load),
        .load_val (b_init),
        .ser_in   (1'b0),
        .q        (b_lsb)
    );

    serial_shift_reg #(.WIDTH(WIDTH), .OUT_WIDTH(WIDTH)) u_res_sh (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (shift),
        .load     (1'b0),
        .load_val ('0),
        .ser_in   (fa_sum),
        .q        (res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            carry  <= carry_next;
            cout_q <= cout_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        carry_next = carry;
        cout_next  = cout_q;
        load       = 1'b0;
        shift      = 1'b0;
        if (ena) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        load       = 1'b1;
                        carry_next = bus.sub ? 1'b1 : bus.cin;
                        cnt_next   = '0;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    shift      = 1'b1;
                    carry_next = fa_cout;
                    cnt_next   = cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout_next  = fa_cout;
                        cnt_next   = '0;
                        state_next = DONE;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign fa_a     = (state == RUN) & a_lsb;
    assign fa_b     = (state == RUN) & b_lsb;
    assign fa_cin   = (state == RUN) & carry;

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = res;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench for serial_add_sequencer with a behavioural full-adder cell.
module tb_serial_add_sequencer;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int unsigned  due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b0;
    logic fa_a, fa_b, fa_cin, fa_sum, fa_cout;

    exp_t        exp_q[$];
    int unsigned done_times[$];
    int unsigned en_cnt   = 0;
    int unsigned cyc      = 0;
    int unsigned busy_run = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    serial_add_sequencer_if #(.WIDTH(W)) bus ();

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .bus     (bus),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout)
    );

    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input int unsigned due);
        exp_t        e;
        int unsigned r;
        if (s) begin
            r      = (32'(a) + 2**W - 32'(b)) % 2**W;
            e.cout = (a >= b);
        end else begin
            r      = 32'(a) + 32'(b) + 32'(ci);
            e.cout = (r >= 2**W);
            r      = r % 2**W;
        end
        e.sum = W'(r);
        e.due = due;
        return e;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (ena && rst_n) en_cnt++;
    end

    // Monitor: record accepted requests, score each done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            busy_run = 0;
        end else begin
            if (ena && bus.start && !bus.busy && !bus.done)
                exp_q.push_back(model(bus.sub, bus.op_a, bus.op_b, bus.cin, en_cnt + 1 + W));
            if (ena && bus.busy) busy_run++;
            if (ena && bus.done) begin
                check("done_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sum", 32'(bus.sum), 32'(e.sum));
                    check("cout", 32'(bus.cout), 32'(e.cout));
                    check("latency", en_cnt, e.due);
                    check("busy_cycles", busy_run, W);
                end
                busy_run = 0;
                done_times.push_back(cyc);
            end
        end
    end

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (!bus.busy && !bus.done && exp_q.size() == 0) ok = 1'b1;
        end
        check({"idle_", tag}, 32'(ok), 1);
    endtask

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        @(posedge clk);
        #1;
        bus.sub   = s;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = ci;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    logic [W-1:0] d_a   [5] = '{8'h3C, 8'hFF, 8'hFF, 8'h10, 8'h01};
    logic [W-1:0] d_b   [5] = '{8'h5A, 8'h01, 8'h00, 8'h01, 8'h02};
    logic         d_s   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic         d_c   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] d_sum [5] = '{8'h96, 8'h00, 8'h00, 8'h0F, 8'hFF};
    logic         d_co  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int unsigned  k, c0;
        logic [W-1:0] sa, sb;
        int unsigned  carries;
        bit           seen;

        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.cin   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_sum", 32'(bus.sum), 0);
        check("rst_cout", 32'(bus.cout), 0);
        check("rst_fa", 32'({fa_a, fa_b, fa_cin}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ena   = 1'b1;

        for (int i = 0; i < 5; i++) begin
            issue(d_s[i], d_a[i], d_b[i], d_c[i]);
            wait_idle("dir");
            check("dir_sum", 32'(bus.sum), 32'(d_sum[i]));
            check("dir_cout", 32'(bus.cout), 32'(d_co[i]));
        end
        repeat (5) @(posedge clk);
        #1;
        check("sum_hold", 32'(bus.sum), 32'h0000_00FF);

        // start while running is ignored
        k = done_times.size();
        issue(1'b0, 8'h12, 8'h34, 1'b0);
        @(posedge clk);
        #1;
        bus.op_a  = 8'h77;
        bus.op_b  = 8'h88;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle("runstart");
        check("single_done", done_times.size() - k, 1);
        check("runstart_sum", 32'(bus.sum), 32'h0000_0046);

        // three-cycle stall mid-run
        sa = 8'hA5;
        sb = 8'h3C;
        carries = (32'(sa) + 32'(sb) + 1) ^ 32'(sa) ^ 32'(sb);
        issue(1'b0, sa, sb, 1'b1);
        c0 = cyc;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_fa_a", 32'(fa_a), 32'(sa[3]));
            check("stall_fa_b", 32'(fa_b), 32'(sb[3]));
            check("stall_fa_cin", 32'(fa_cin), (carries >> 3) & 1);
            check("stall_busy", 32'(bus.busy), 1);
        end
        @(posedge clk);
        #1;
        ena = 1'b1;
        wait_idle("stall");
        check("stall_sum", 32'(bus.sum), 32'h0000_00E2);
        check("stall_latency", done_times[done_times.size() - 1] - c0, W + 3);

        // done stretches while disabled
        k = done_times.size();
        issue(1'b0, 8'h01, 8'h02, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 1);
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("done_stretch", 32'(bus.done), 1);
        end
        @(posedge clk);
        #1;
        ena = 1'b1;
        @(posedge clk);
        #1;
        check("done_clear", 32'(bus.done), 0);
        wait_idle("stretch");
        check("stretch_one_done", done_times.size() - k, 1);

        // start held high: one operation every W+2 cycles
        k = done_times.size();
        @(posedge clk);
        #1;
        bus.sub   = 1'b0;
        bus.op_a  = 8'h11;
        bus.op_b  = 8'h22;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        for (int i = 0; i < 100 && done_times.size() < k + 3; i++) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle("tput");
        check("tput_count", 32'(done_times.size() >= k + 3), 1);
        if (done_times.size() >= k + 3) begin
            check("tput_gap1", done_times[k + 1] - done_times[k], W + 2);
            check("tput_gap2", done_times[k + 2] - done_times[k + 1], W + 2);
        end

        // asynchronous reset mid-run
        k = done_times.size();
        issue(1'b0, 8'hF0, 8'h0F, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_done", 32'(bus.done), 0);
        check("arst_sum", 32'(bus.sum), 0);
        check("arst_cout", 32'(bus.cout), 0);
        check("arst_fa", 32'({fa_a, fa_b, fa_cin}), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(1'b0, 8'h01, 8'h01, 1'b0);
        wait_idle("arst");
        check("arst_new_sum", 32'(bus.sum), 32'h0000_0002);
        check("arst_one_done", done_times.size() - k, 1);

        // randomized traffic with random enable gaps
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            bus.op_a  = W'($urandom);
            bus.op_b  = W'($urandom);
            bus.sub   = 1'($urandom);
            bus.cin   = 1'($urandom);
            bus.start = ($urandom_range(0, 3) != 0);
            ena       = ($urandom_range(0, 7) != 0);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ena       = 1'b1;
        wait_idle("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
